// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared types for the regfile writeback arbiter and scoreboard
package regfile_ctrl_pkg;

  localparam int NREG = 32;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_A    = 2'd1,
    SRC_B    = 2'd2
  } wb_src_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - outstanding long-latency result tracking, WAW issue stall and decode hazard
// Optional WB_BYPASS_EN: hazard masks a register whose B result is retiring this cycle.
module regfile_scoreboard
  import regfile_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            nrst,
  input  logic            iss_valid,
  input  reg_addr_t       iss_rd,
  output logic            iss_ready,
  input  logic            retire_valid,
  input  reg_addr_t       retire_addr,
  input  reg_addr_t       rs1addr,
  input  reg_addr_t       rs2addr,
  output logic            hazard,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:1] busy_q;
  logic [NREG-1:1] set_mask;
  logic [NREG-1:1] clr_mask;
  logic [NREG-1:0] hz_busy;
  logic            set_en;

  // x0 is never tracked, so bit 0 of the lookup vector is tied low
  assign busy      = {busy_q, 1'b0};
  assign iss_ready = !busy[iss_rd];
  assign set_en    = iss_valid && iss_ready;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 1; i < NREG; i++) begin
      set_mask[i] = set_en && (iss_rd == reg_addr_t'(i));
      clr_mask[i] = retire_valid && (retire_addr == reg_addr_t'(i));
    end
  end

  always_comb begin
    hz_busy = busy;
`ifdef WB_BYPASS_EN
    hz_busy = busy & {~clr_mask, 1'b1};
`endif
    hazard = hz_busy[rs1addr] | hz_busy[rs2addr];
  end

  // A new issue to the same register outranks a retirement in the same cycle
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - arbitrates the regfile write port between execute (A) and load/mul-div (B)
// Optional WB_BYPASS_EN: forwards the write-stage result to decode operands.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [4:0]       a_addr,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [4:0]       b_addr,
  input  logic [WIDTH-1:0] b_data,
  input  logic             iss_valid,
  input  logic [4:0]       iss_rd,
  output logic             iss_ready,
  input  logic [4:0]       rs1addr,
  input  logic [4:0]       rs2addr,
  output logic             hazard,
  input  logic [WIDTH-1:0] rf_rs1data,
  input  logic [WIDTH-1:0] rf_rs2data,
  output logic [WIDTH-1:0] rs1data,
  output logic [WIDTH-1:0] rs2data,
  output logic             enw,
  output logic [4:0]       rdaddr,
  output logic [WIDTH-1:0] rddata
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0]      wait_cnt;
  wb_src_e         wr_src;
  logic            grant_a;
  logic            grant_b;
  logic            retire_b;
  logic [NREG-1:0] busy;

  // A normally wins; B only overrides once it has been refused MAX_WAIT times
  always_comb begin
    grant_b = b_valid && (!a_valid || (wait_cnt == WAIT_LIMIT));
    grant_a = a_valid && !grant_b;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wait_cnt <= '0;
    end else if (!b_valid || grant_b) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      enw    <= 1'b0;
      rdaddr <= '0;
      rddata <= '0;
      wr_src <= SRC_NONE;
    end else if (grant_b) begin
      enw    <= (b_addr != 5'd0);
      rdaddr <= b_addr;
      rddata <= b_data;
      wr_src <= SRC_B;
    end else if (grant_a) begin
      enw    <= (a_addr != 5'd0);
      rdaddr <= a_addr;
      rddata <= a_data;
      wr_src <= SRC_A;
    end else begin
      enw    <= 1'b0;
      wr_src <= SRC_NONE;
    end
  end

  assign retire_b = enw && (wr_src == SRC_B);

  regfile_scoreboard u_scoreboard (
    .clk          (clk),
    .nrst         (nrst),
    .iss_valid    (iss_valid),
    .iss_rd       (iss_rd),
    .iss_ready    (iss_ready),
    .retire_valid (retire_b),
    .retire_addr  (rdaddr),
    .rs1addr      (rs1addr),
    .rs2addr      (rs2addr),
    .hazard       (hazard),
    .busy         (busy)
  );

`ifdef WB_BYPASS_EN
  always_comb begin
    rs1data = (enw && (rdaddr == rs1addr) && (rs1addr != 5'd0)) ? rddata : rf_rs1data;
    rs2data = (enw && (rdaddr == rs2addr) && (rs2addr != 5'd0)) ? rddata : rf_rs2data;
  end
`else
  assign rs1data = rf_rs1data;
  assign rs2data = rf_rs2data;
`endif

`ifndef SYNTHESIS
  // A must never target a register still owed a B result; B must only write owed registers
  a_writes_busy_reg : assert property (@(posedge clk) disable iff (!nrst)
    !(grant_a && (a_addr != 5'd0) && busy[a_addr]));
  b_writes_idle_reg : assert property (@(posedge clk) disable iff (!nrst)
    !(grant_b && (b_addr != 5'd0) && !busy[b_addr]));
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        a_valid, b_valid, iss_valid;
  logic        a_ready, b_ready, iss_ready, hazard, enw;
  logic [4:0]  a_addr, b_addr, iss_rd, rs1addr, rs2addr, rdaddr;
  logic [31:0] a_data, b_data, rf_rs1data, rf_rs2data, rs1data, rs2data, rddata;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.WIDTH(32), .MAX_WAIT(4)) dut (
    .clk(clk), .nrst(nrst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1addr(rs1addr), .rs2addr(rs2addr), .hazard(hazard),
    .rf_rs1data(rf_rs1data), .rf_rs2data(rf_rs2data),
    .rs1data(rs1data), .rs2data(rs2data),
    .enw(enw), .rdaddr(rdaddr), .rddata(rddata)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    iss_valid = 0; iss_rd = 0;
    rs1addr = 0; rs2addr = 0; rf_rs1data = 0; rf_rs2data = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    @(negedge clk);
    iss_valid = 1; iss_rd = rd;
    @(posedge clk); #1;
    iss_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    nrst = 0;
    a_valid = 1; a_addr = 5'd9; a_data = 32'h5555_0000;
    iss_rd = 5'd5; rs1addr = 5'd5; rs2addr = 5'd6;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (enw !== 1'b0) begin errors++; $display("FAIL reset_enw got %0b want 0", enw); end
    checks++; if (rdaddr !== 5'd0) begin errors++; $display("FAIL reset_rdaddr got %0d want 0", rdaddr); end
    checks++; if (rddata !== 32'd0) begin errors++; $display("FAIL reset_rddata got %h want 0", rddata); end
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL reset_iss_ready got %0b want 1", iss_ready); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %0b want 0", hazard); end
    idle_inputs();
    nrst = 1;
  endtask

  task automatic test_a_only();
    @(negedge clk);
    a_valid = 1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL a_only_ready got %0b want 1", a_ready); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL a_only_b_ready got %0b want 0", b_ready); end
    @(posedge clk); #1;
    a_valid = 0;
    checks++; if (enw !== 1'b1) begin errors++; $display("FAIL a_only_enw got %0b want 1", enw); end
    checks++; if (rdaddr !== 5'd5) begin errors++; $display("FAIL a_only_rdaddr got %0d want 5", rdaddr); end
    checks++; if (rddata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL a_only_rddata got %h want deadbeef", rddata); end
    @(posedge clk); #1;
    checks++; if (enw !== 1'b0) begin errors++; $display("FAIL a_only_idle_enw got %0b want 0", enw); end
    checks++; if (rddata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL a_only_hold_rddata got %h want deadbeef", rddata); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    a_valid = 1; a_addr = 5'd0; a_data = 32'h0000_1234;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %0b want 1", a_ready); end
    @(posedge clk); #1;
    a_valid = 0;
    checks++; if (enw !== 1'b0) begin errors++; $display("FAIL x0_enw got %0b want 0", enw); end
    issue(5'd0);
    @(negedge clk);
    iss_rd = 5'd0; rs1addr = 5'd0; rs2addr = 5'd0;
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL x0_iss_ready got %0b want 1", iss_ready); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL x0_hazard got %0b want 0", hazard); end
  endtask

  task automatic test_scoreboard();
    logic exp_hz;
    issue(5'd7);
    @(negedge clk);
    rs1addr = 5'd7; iss_rd = 5'd7;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_hazard_set got %0b want 1", hazard); end
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL sb_waw_stall got %0b want 0", iss_ready); end
    b_valid = 1; b_addr = 5'd7; b_data = 32'h0000_0077;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL sb_b_ready got %0b want 1", b_ready); end
    @(posedge clk); #1;
    checks++; if ({enw, rdaddr} !== {1'b1, 5'd7}) begin errors++; $display("FAIL sb_b_write got enw=%0b rdaddr=%0d want enw=1 rdaddr=7", enw, rdaddr); end
    @(negedge clk);
    b_valid = 0;
    #1;
`ifdef WB_BYPASS_EN
    exp_hz = 1'b0;
`else
    exp_hz = 1'b1;
`endif
    checks++; if (hazard !== exp_hz) begin errors++; $display("FAIL sb_hazard_retiring got %0b want %0b", hazard, exp_hz); end
    @(posedge clk); #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL sb_hazard_cleared got %0b want 0", hazard); end
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sb_iss_ready_cleared got %0b want 1", iss_ready); end
    rs1addr = 0; iss_rd = 0;
  endtask

  task automatic test_starvation();
    issue(5'd9);
    @(negedge clk);
    a_valid = 1; a_addr = 5'd10; a_data = 32'h0000_00AA;
    b_valid = 1; b_addr = 5'd9;  b_data = 32'h0000_00BB;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL starve_refused_%0d got a=%0b b=%0b want a=1 b=0", c, a_ready, b_ready); end
      @(negedge clk);
    end
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b01) begin errors++; $display("FAIL starve_b_wins got a=%0b b=%0b want a=0 b=1", a_ready, b_ready); end
    @(posedge clk); #1;
    checks++; if (dut.wait_cnt !== 4'd0) begin errors++; $display("FAIL starve_wait_cnt got %0d want 0", dut.wait_cnt); end
    checks++; if ({enw, rdaddr, rddata} !== {1'b1, 5'd9, 32'h0000_00BB}) begin errors++; $display("FAIL starve_b_write got enw=%0b rdaddr=%0d rddata=%h want 1/9/bb", enw, rdaddr, rddata); end
    @(negedge clk); #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL starve_a_next got a=%0b b=%0b want a=1 b=0", a_ready, b_ready); end
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
    checks++; if ({enw, rdaddr} !== {1'b1, 5'd10}) begin errors++; $display("FAIL starve_a_write got enw=%0b rdaddr=%0d want 1/10", enw, rdaddr); end
  endtask

  task automatic test_bypass_and_reset();
    logic [31:0] exp_rs2;
    @(negedge clk);
    a_valid = 1; a_addr = 5'd3; a_data = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    a_valid = 0;
    rs2addr = 5'd3; rf_rs2data = 32'd0;
    rs1addr = 5'd4; rf_rs1data = 32'h1111_1111;
    #1;
`ifdef WB_BYPASS_EN
    exp_rs2 = 32'hA5A5_A5A5;
`else
    exp_rs2 = 32'd0;
`endif
    checks++; if (rs2data !== exp_rs2) begin errors++; $display("FAIL bypass_rs2 got %h want %h", rs2data, exp_rs2); end
    checks++; if (rs1data !== 32'h1111_1111) begin errors++; $display("FAIL bypass_rs1_passthru got %h want 11111111", rs1data); end
    issue(5'd12);
    issue(5'd13);
    @(negedge clk);
    rs1addr = 5'd12; rs2addr = 5'd13; iss_rd = 5'd13;
    b_valid = 1; b_addr = 5'd12; b_data = 32'h0000_0C0C;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL burst_hazard got %0b want 1", hazard); end
    @(posedge clk); #2;
    nrst = 0; b_valid = 0;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL async_reset_hazard got %0b want 0", hazard); end
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL async_reset_iss_ready got %0b want 1", iss_ready); end
    checks++; if (enw !== 1'b0) begin errors++; $display("FAIL async_reset_enw got %0b want 0", enw); end
    @(negedge clk);
    nrst = 1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_x0();
    test_scoreboard();
    test_starvation();
    test_bypass_and_reset();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
